// File: rtl/mips_hazard_unit_if.sv
// Interface between the ID stage and the hazard unit: the ID-stage instruction
// description going in, and the stall / forwarding / statistics coming out.
interface mips_hazard_unit_if #(
    parameter int REG_NUM = 32,
    parameter int STAGES  = 3,
    parameter int CNT_W   = 32
);
    localparam int REG_W = $clog2(REG_NUM);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_reg_write;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             flush;

    logic             stall;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] hazard_count;

    // ID stage / pipeline control side
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_reg_write, id_rd, id_is_load, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_count, hazard_count
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_reg_write, id_rd, id_is_load, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_count, hazard_count
    );
endinterface

// File: rtl/mips_hazard_unit.sv
// Hazard detection and forwarding control for the MIPS-lite 5-stage pipeline.
// A small scoreboard shadows the destination registers of the instructions in
// EX..WB; the ID instruction's sources are compared against it every cycle to
// produce a combinational stall and per-operand forwarding selects.
module mips_hazard_unit #(
    parameter int REG_NUM    = 32,
    parameter int STAGES     = 3,
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_hazard_unit_if.slave   hz
);
    localparam int REG_W = $clog2(REG_NUM);
    localparam int SEL_W = $clog2(STAGES + 1);

    // Scoreboard: entry 0 = EX, entry STAGES-1 = WB
    logic             sb_valid_reg [STAGES];
    logic [REG_W-1:0] sb_rd_reg    [STAGES];
    logic             sb_load_reg  [STAGES];

    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] hazard_count_reg;
    logic             counted_reg;

    // Per-entry hits for the entries that can cause a hazard (EX..stage before WB)
    logic [STAGES-2:0] hit_a;
    logic [STAGES-2:0] hit_b;

    logic             check_a;
    logic             check_b;
    logic             match_a;
    logic             match_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             load_use;
    logic             stall;
    logic             accept;
    logic             any_match;

    // A source only participates if it is actually read and is not r0
    assign check_a = hz.id_uses_rs && (hz.id_rs != '0);
    assign check_b = hz.id_uses_rt && (hz.id_rt != '0);

    // The WB entry is excluded: the register file writes before it is read
    generate
        for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_hit
            assign hit_a[gi] = sb_valid_reg[gi] && (sb_rd_reg[gi] == hz.id_rs);
            assign hit_b[gi] = sb_valid_reg[gi] && (sb_rd_reg[gi] == hz.id_rt);
        end
    endgenerate

    assign match_a = check_a && (|hit_a);
    assign match_b = check_b && (|hit_b);

    // Priority-encode the youngest (lowest index) producer for each operand
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = STAGES - 2; k >= 0; k--) begin
            if (hit_a[k]) sel_a = SEL_W'(k + 1);
            if (hit_b[k]) sel_b = SEL_W'(k + 1);
        end
    end

    // A load still in EX cannot forward in time: its data exists only after MEM
    assign load_use = sb_load_reg[0] &&
                      ((check_a && hit_a[0]) || (check_b && hit_b[0]));

    // Decide stall and forwarding according to the pipeline flavour
    generate
        if (FORWARDING != 0) begin : g_fwd
            assign stall        = hz.id_valid && !hz.flush && load_use;
            assign hz.fwd_a_sel = (!stall && match_a) ? sel_a : '0;
            assign hz.fwd_b_sel = (!stall && match_b) ? sel_b : '0;
        end else begin : g_nofwd
            assign stall        = hz.id_valid && !hz.flush && (match_a || match_b);
            assign hz.fwd_a_sel = '0;
            assign hz.fwd_b_sel = '0;
        end
    endgenerate

    assign hz.stall        = stall;
    assign accept          = hz.id_valid && !stall && !hz.flush;
    assign any_match       = hz.id_valid && !hz.flush && (match_a || match_b);
    assign hz.stall_count  = stall_count_reg;
    assign hz.hazard_count = hazard_count_reg;

    // Shift the scoreboard one stage per cycle; entry 0 takes ID or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sb_valid_reg[k] <= 1'b0;
                sb_rd_reg[k]    <= '0;
                sb_load_reg[k]  <= 1'b0;
            end
        end else begin
            sb_valid_reg[0] <= accept && hz.id_reg_write && (hz.id_rd != '0);
            sb_rd_reg[0]    <= hz.id_rd;
            sb_load_reg[0]  <= hz.id_is_load;
            for (int k = 1; k < STAGES; k++) begin
                sb_valid_reg[k] <= sb_valid_reg[k-1];
                sb_rd_reg[k]    <= sb_rd_reg[k-1];
                sb_load_reg[k]  <= sb_load_reg[k-1];
            end
        end
    end

    // Saturating statistics; `counted` stops a held instruction being recounted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg  <= '0;
            hazard_count_reg <= '0;
            counted_reg      <= 1'b0;
        end else begin
            if (stall && (stall_count_reg != {CNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + 1'b1;
            if (any_match && !counted_reg && (hazard_count_reg != {CNT_W{1'b1}}))
                hazard_count_reg <= hazard_count_reg + 1'b1;
            // A stall implies a match, so the flag is simply "held by a stall"
            counted_reg <= stall;
        end
    end
endmodule

// File: tb/tb_mips_hazard_unit.sv
// Directed bench for mips_hazard_unit: one forwarding build (32-bit counters)
// and one non-forwarding build with 4-bit counters for saturation.
module tb_mips_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_hazard_unit_if #(.REG_NUM(32), .STAGES(3), .CNT_W(32)) hf ();
    mips_hazard_unit_if #(.REG_NUM(32), .STAGES(3), .CNT_W(4))  hn ();

    mips_hazard_unit #(.REG_NUM(32), .STAGES(3), .FORWARDING(1), .CNT_W(32)) u_fwd (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hf)
    );

    mips_hazard_unit #(.REG_NUM(32), .STAGES(3), .FORWARDING(0), .CNT_W(4)) u_nof (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        if (obs === exp) $display("check %s observed=%0d expected=%0d ok", tag, obs, exp);
    endtask

    task automatic drive_f(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic wr,
                           input logic [4:0] rd, input logic ld, input logic fl);
        hf.id_valid = v;   hf.id_rs = rs;  hf.id_rt = rt;
        hf.id_uses_rs = urs; hf.id_uses_rt = urt; hf.id_reg_write = wr;
        hf.id_rd = rd;     hf.id_is_load = ld; hf.flush = fl;
    endtask

    task automatic drive_n(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic wr,
                           input logic [4:0] rd, input logic ld, input logic fl);
        hn.id_valid = v;   hn.id_rs = rs;  hn.id_rt = rt;
        hn.id_uses_rs = urs; hn.id_uses_rt = urt; hn.id_reg_write = wr;
        hn.id_rd = rd;     hn.id_is_load = ld; hn.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_f(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_n(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_f_stall",  32'(hf.stall), 0);
        check("rst_f_sela",   32'(hf.fwd_a_sel), 0);
        check("rst_f_scnt",   hf.stall_count, 0);
        check("rst_f_hcnt",   hf.hazard_count, 0);
        check("rst_n_scnt",   32'(hn.stall_count), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- FORWARDING=1: lw r2 ; add r3,r2,r4 (load-use) ----
        drive_f(1, 1, 0, 1, 0, 1, 2, 1, 0); #1;
        check("fA_c0_stall", 32'(hf.stall), 0);
        tick();
        drive_f(1, 2, 4, 1, 1, 1, 3, 0, 0); #1;
        check("fA_c1_stall", 32'(hf.stall), 1);
        check("fA_c1_sela",  32'(hf.fwd_a_sel), 0);
        tick();
        check("fA_c2_stall", 32'(hf.stall), 0);
        check("fA_c2_sela",  32'(hf.fwd_a_sel), 2);
        check("fA_c2_selb",  32'(hf.fwd_b_sel), 0);
        tick();
        drive_f(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fA_scnt", hf.stall_count, 1);
        check("fA_hcnt", hf.hazard_count, 1);
        tick(); tick(); tick();

        // ---- FORWARDING=1: add r5,r1,r1 ; sub r6,r5,r5 (EX forward) ----
        drive_f(1, 1, 1, 1, 1, 1, 5, 0, 0); #1;
        check("fB_c0_stall", 32'(hf.stall), 0);
        check("fB_c0_sela",  32'(hf.fwd_a_sel), 0);
        tick();
        drive_f(1, 5, 5, 1, 1, 1, 6, 0, 0); #1;
        check("fB_c1_stall", 32'(hf.stall), 0);
        check("fB_c1_sela",  32'(hf.fwd_a_sel), 1);
        check("fB_c1_selb",  32'(hf.fwd_b_sel), 1);
        tick();
        drive_f(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fB_hcnt", hf.hazard_count, 2);
        check("fB_scnt", hf.stall_count, 1);
        tick(); tick(); tick();

        // ---- r0 producer, and a consumer not reading rs ----
        drive_f(1, 1, 1, 1, 1, 1, 0, 1, 0);          // lw r0
        tick();
        drive_f(1, 0, 0, 1, 1, 1, 4, 0, 0); #1;      // reads r0
        check("fC_r0_stall", 32'(hf.stall), 0);
        check("fC_r0_sela",  32'(hf.fwd_a_sel), 0);
        check("fC_r0_selb",  32'(hf.fwd_b_sel), 0);
        tick();
        drive_f(1, 1, 1, 1, 1, 1, 7, 1, 0);          // lw r7
        tick();
        drive_f(1, 7, 8, 0, 1, 1, 9, 0, 0); #1;      // rs=r7 but unused
        check("fC_nors_stall", 32'(hf.stall), 0);
        check("fC_nors_sela",  32'(hf.fwd_a_sel), 0);
        check("fC_nors_selb",  32'(hf.fwd_b_sel), 0);
        tick();
        drive_f(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fC_scnt", hf.stall_count, 1);
        check("fC_hcnt", hf.hazard_count, 2);
        tick(); tick(); tick();

        // ---- load-use coincident with flush ----
        drive_f(1, 1, 1, 1, 0, 1, 9, 1, 0);          // lw r9
        tick();
        drive_f(1, 9, 0, 1, 0, 1, 9, 1, 1); #1;      // squashed load of r9
        check("fD_flush_stall", 32'(hf.stall), 0);
        tick();
        drive_f(1, 9, 0, 1, 0, 1, 10, 0, 0); #1;     // squashed one must not be in EX
        check("fD_next_stall", 32'(hf.stall), 0);
        check("fD_next_sela",  32'(hf.fwd_a_sel), 2);
        tick();
        drive_f(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fD_scnt", hf.stall_count, 1);
        check("fD_hcnt", hf.hazard_count, 3);
        tick(); tick(); tick();

        // ---- async reset during a stall ----
        drive_f(1, 1, 1, 1, 0, 1, 10, 1, 0);         // lw r10
        tick();
        drive_f(1, 10, 0, 1, 0, 1, 11, 0, 0); #1;
        check("fE_pre_stall", 32'(hf.stall), 1);
        rst_n = 1'b0;
        #1;
        check("fE_rst_stall", 32'(hf.stall), 0);
        check("fE_rst_sela",  32'(hf.fwd_a_sel), 0);
        check("fE_rst_scnt",  hf.stall_count, 0);
        check("fE_rst_hcnt",  hf.hazard_count, 0);
        drive_f(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- FORWARDING=0: lw r2 ; add r3,r2,r4 stalls until WB ----
        drive_n(1, 1, 0, 1, 0, 1, 2, 1, 0); #1;
        check("nA_c0_stall", 32'(hn.stall), 0);
        tick();
        drive_n(1, 2, 4, 1, 1, 1, 3, 0, 0); #1;
        check("nA_c1_stall", 32'(hn.stall), 1);
        check("nA_c1_sela",  32'(hn.fwd_a_sel), 0);
        tick();
        check("nA_c2_stall", 32'(hn.stall), 1);
        check("nA_c2_sela",  32'(hn.fwd_a_sel), 0);
        tick();
        check("nA_c3_stall", 32'(hn.stall), 0);
        check("nA_c3_sela",  32'(hn.fwd_a_sel), 0);
        tick();
        drive_n(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("nA_scnt", 32'(hn.stall_count), 2);
        check("nA_hcnt", 32'(hn.hazard_count), 1);

        // ---- 4-bit counter saturation: 2 stalls per pair ----
        for (int i = 1; i <= 8; i++) begin
            drive_n(1, 1, 0, 1, 0, 1, 2, 1, 0);
            tick();
            drive_n(1, 2, 4, 1, 1, 1, 3, 0, 0);
            tick(); tick(); tick();
            drive_n(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("nS_scnt_%0d", i), 32'(hn.stall_count),
                  (2 + 2 * i > 15) ? 32'd15 : 32'(2 + 2 * i));
            check($sformatf("nS_hcnt_%0d", i), 32'(hn.hazard_count), 32'(1 + i));
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
